// File: rtl/pc_stack_ctrl_if.sv
// Decoder-to-sequencer opcode handshake for pc_stack_ctrl.
interface pc_stack_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              op_valid;
  logic              op_ready;
  logic [7:0]        op_code;
  logic [DATA_W-1:0] op_val;
  logic [DATA_W-1:0] op_a;
  logic              cond;

  modport master (output op_valid, op_code, op_val, op_a, cond, input op_ready);
  modport slave  (input op_valid, op_code, op_val, op_a, cond, output op_ready);
endinterface

// File: rtl/pc_stack_ctrl.sv
// Program counter and hardware call/return stack sequencer (fetch/decode/exec/wait).
// Optional macro PCSTK_TRAP_EN: stack faults pulse trap and force pc to 0.
module pc_stack_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 4,
  parameter int unsigned SPTR_W = 4
) (
  input  logic                clkout,
  input  logic                rst,
  pc_stack_ctrl_if.slave      bus,
  input  logic                alu_busy,
  output logic [PC_W-1:0]     pc,
  output logic                fetch_en,
  output logic [SPTR_W:0]     sp_cnt,
  output logic [DATA_W-1:0]   pop_data,
  output logic                pop_valid,
  output logic                stk_ovf,
  output logic                stk_unf,
  output logic                trap
);
  localparam int unsigned DEPTH = 1 << SPTR_W;
  localparam int unsigned CNT_W = SPTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [5:0]        code_q;
  logic [DATA_W-1:0] val_q, a_q;
  logic              cond_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;

  logic [PC_W-1:0]   pc_inc, pc_nxt, target;
  logic [DATA_W-1:0] push_word, top_word;
  logic [SPTR_W-1:0] push_addr, pop_addr;
  logic [CNT_W-1:0]  mvs_cnt;
  logic want_push, want_pop, is_call, is_ret, jump, do_mvs, taken, full, empty;
  logic push_en, pop_en, ovf_ev, unf_ev, fault, trap_ev;

  assign accept = (state == S_DECODE) && bus.op_valid && bus.op_ready;

  // State register; fetch strobe trails S_FETCH by one edge, ready mirrors S_DECODE
  always_ff @(posedge clkout) begin
    if (rst) begin
      state        <= S_FETCH;
      fetch_en     <= 1'b0;
      bus.op_ready <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_en     <= (state == S_FETCH);
      bus.op_ready <= (state_nxt == S_DECODE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: if (accept) state_nxt = (bus.op_code[7:6] == 2'b11) ? S_EXEC : S_WAIT;
      S_EXEC:   state_nxt = S_FETCH;
      S_WAIT:   if (!alu_busy) state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Control-op decode: stack effect and next pc for the latched opcode
  always_comb begin
    pc_inc    = pc + PC_W'(1);
    full      = (sp_cnt == FULL_CNT);
    empty     = (sp_cnt == '0);
    push_addr = SPTR_W'(FULL_CNT - CNT_W'(1) - sp_cnt);
    pop_addr  = SPTR_W'(FULL_CNT - sp_cnt);
    top_word  = mem[pop_addr];
    taken     = !code_q[4] || cond_q;
    mvs_cnt   = (val_q > DATA_W'(DEPTH)) ? FULL_CNT : CNT_W'(val_q);
    want_push = 1'b0;
    want_pop  = 1'b0;
    is_call   = 1'b0;
    is_ret    = 1'b0;
    jump      = 1'b0;
    do_mvs    = 1'b0;
    target    = '0;
    push_word = val_q;
    case (code_q)
      6'h01, 6'h21: begin want_push = 1'b1; push_word = code_q[5] ? a_q : val_q; end
      6'h02:        want_pop = 1'b1;
      6'h03:        do_mvs = 1'b1;
      6'h04, 6'h14: begin jump = taken; target = PC_W'(val_q); end
      6'h05, 6'h15: begin jump = taken; target = pc + PC_W'(val_q); end
      6'h06, 6'h16: begin jump = taken; target = PC_W'(a_q); end
      6'h07, 6'h17: begin is_call = taken; target = PC_W'(val_q); end
      6'h08, 6'h18: begin is_call = taken; target = pc + PC_W'(val_q); end
      6'h09, 6'h19: begin is_call = taken; target = PC_W'(a_q); end
      6'h0A, 6'h1A: is_ret = taken;
      default: ;
    endcase
    if (is_call) begin
      want_push = 1'b1;
      push_word = DATA_W'(pc_inc);
    end
    if (is_ret) want_pop = 1'b1;
    ovf_ev  = want_push && full;
    push_en = want_push && !full;
    unf_ev  = want_pop && empty;
    pop_en  = want_pop && !empty;
    fault   = ovf_ev || unf_ev;
    pc_nxt  = pc_inc;
    if (jump || (is_call && push_en)) pc_nxt = target;
    if (is_ret && pop_en) pc_nxt = PC_W'(top_word);
`ifdef PCSTK_TRAP_EN
    trap_ev = fault;
    if (fault) pc_nxt = '0;
`else
    trap_ev = 1'b0;
`endif
  end

  always_ff @(posedge clkout) begin
    if (accept) begin
      code_q <= bus.op_code[5:0];
      val_q  <= bus.op_val;
      a_q    <= bus.op_a;
      cond_q <= bus.cond;
    end
  end

  always_ff @(posedge clkout) begin
    if (state == S_EXEC && push_en) mem[push_addr] <= push_word;
  end

  always_ff @(posedge clkout) begin
    if (rst) begin
      pc        <= '0;
      sp_cnt    <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
      trap      <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      trap      <= 1'b0;
      if (state == S_EXEC) begin
        pc   <= pc_nxt;
        trap <= trap_ev;
        if (push_en) begin
          sp_cnt <= sp_cnt + CNT_W'(1);
        end else if (pop_en) begin
          sp_cnt    <= sp_cnt - CNT_W'(1);
          pop_data  <= top_word;
          pop_valid <= 1'b1;
        end else if (do_mvs) begin
          sp_cnt <= mvs_cnt;
        end
        if (ovf_ev) stk_ovf <= 1'b1;
        if (unf_ev) stk_unf <= 1'b1;
      end else if (state == S_WAIT && !alu_busy) begin
        pc <= pc_inc;
      end
    end
  end
endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Scoreboard bench for pc_stack_ctrl: queue-based stack model, one expectation per fetch.
module tb_pc_stack_ctrl;
  localparam int NPC = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alu_busy = 1'b0;
  logic [3:0]  pc;
  logic        fetch_en;
  logic [4:0]  sp_cnt;
  logic [31:0] pop_data;
  logic        pop_valid, stk_ovf, stk_unf, trap;

  pc_stack_ctrl_if #(.DATA_W(32)) bus ();

  pc_stack_ctrl #(.DATA_W(32), .PC_W(4), .SPTR_W(4)) dut (
    .clkout(clk), .rst(rst), .bus(bus), .alu_busy(alu_busy), .pc(pc),
    .fetch_en(fetch_en), .sp_cnt(sp_cnt), .pop_data(pop_data),
    .pop_valid(pop_valid), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .trap(trap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; int pc; int cnt; bit ovf; bit unf;
    logic [31:0] pdata; int npop; int ntrap;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  int mon_pop = 0;
  int mon_trap = 0;

  // Reference model state
  int          m_pc;
  logic [31:0] m_stk[$];
  bit          m_ovf, m_unf;
  logic [31:0] m_pop;
  int          m_npop, m_ntrap;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_pop = '0;
  endfunction

  function automatic void model_op(input logic [7:0] code, input logic [31:0] val,
                                   input logic [31:0] a, input bit c);
    int nxt, tgt, n;
    bit taken, fault;
    logic [5:0] low;
    m_npop = 0; m_ntrap = 0; fault = 0; tgt = 0;
    nxt = (m_pc + 1) % NPC;
    if (code[7:6] != 2'b11) begin
      m_pc = nxt;
      return;
    end
    taken = !code[4] || c;
    low = code[5:0];
    case (low[3:0])
      4'h4, 4'h7: tgt = int'(val % NPC);
      4'h5, 4'h8: tgt = (m_pc + int'(val % NPC)) % NPC;
      4'h6, 4'h9: tgt = int'(a % NPC);
      default: tgt = 0;
    endcase
    case (low)
      6'h01, 6'h21: begin
        if (m_stk.size() == DEPTH) begin fault = 1; m_ovf = 1; end
        else m_stk.push_back(code[5] ? a : val);
      end
      6'h02: begin
        if (m_stk.size() == 0) begin fault = 1; m_unf = 1; end
        else begin m_pop = m_stk.pop_back(); m_npop = 1; end
      end
      6'h03: begin
        n = (val > 32'(DEPTH)) ? DEPTH : int'(val);
        while (m_stk.size() > n) void'(m_stk.pop_back());
        while (m_stk.size() < n) m_stk.push_back('0);
      end
      6'h04, 6'h14, 6'h05, 6'h15, 6'h06, 6'h16: if (taken) nxt = tgt;
      6'h07, 6'h17, 6'h08, 6'h18, 6'h09, 6'h19: if (taken) begin
        if (m_stk.size() == DEPTH) begin fault = 1; m_ovf = 1; end
        else begin m_stk.push_back(32'(nxt)); nxt = tgt; end
      end
      6'h0A, 6'h1A: if (taken) begin
        if (m_stk.size() == 0) begin fault = 1; m_unf = 1; end
        else begin m_pop = m_stk.pop_back(); m_npop = 1; nxt = int'(m_pop % NPC); end
      end
      default: ;
    endcase
`ifdef PCSTK_TRAP_EN
    if (fault) begin nxt = 0; m_ntrap = 1; end
`endif
    m_pc = nxt;
  endfunction

  // Monitor: strobes are tallied, every fetch retires one expectation
  always @(negedge clk) begin
    if (mon_en) begin
      if (trap) mon_trap++;
      if (pop_valid) mon_pop++;
      if (fetch_en) begin
        if (sbq.size() == 0) begin
          chk("unexpected_fetch", 64'(pc), 64'hFFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("fetch_cycle", 64'(cyc), 64'(e.cyc));
          chk("pc", 64'(pc), 64'(e.pc));
          chk("sp_cnt", 64'(sp_cnt), 64'(e.cnt));
          chk("stk_ovf", 64'(stk_ovf), 64'(e.ovf));
          chk("stk_unf", 64'(stk_unf), 64'(e.unf));
          chk("pop_data", 64'(pop_data), 64'(e.pdata));
          chk("pop_valid_pulses", 64'(mon_pop), 64'(e.npop));
          chk("trap_pulses", 64'(mon_trap), 64'(e.ntrap));
        end
        mon_pop = 0;
        mon_trap = 0;
      end
    end
  end

  task automatic do_reset(input int n);
    mon_en = 0;
    rst = 1;
    bus.op_valid = 0;
    alu_busy = 0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_sp_cnt", 64'(sp_cnt), 64'd0);
    chk("rst_pop_data", 64'(pop_data), 64'd0);
    chk("rst_flags", {59'd0, pop_valid, stk_ovf, stk_unf, trap, fetch_en}, 64'd0);
    chk("rst_op_ready", 64'(bus.op_ready), 64'd0);
    rst = 0;
    sbq.delete();
    mon_pop = 0;
    mon_trap = 0;
    model_reset();
    sbq.push_back('{cyc + 1, 0, 0, 1'b0, 1'b0, 32'd0, 0, 0});
    mon_en = 1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("op_ready_timeout", 64'(bus.op_ready), 64'd1);
  endtask

  task automatic issue(input logic [7:0] code, input logic [31:0] val,
                       input logic [31:0] a, input bit c, input int busy);
    wait_ready();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.op_valid = 1;
    bus.op_code = code;
    bus.op_val = val;
    bus.op_a = a;
    bus.cond = c;
    alu_busy = (busy > 0);
    @(posedge clk);
    #1;
    bus.op_valid = 0;
    bus.op_code = 8'($urandom);
    bus.op_val = $urandom;
    bus.op_a = $urandom;
    bus.cond = 1'($urandom);
    model_op(code, val, a, c);
    sbq.push_back('{cyc + 2 + busy, m_pc, m_stk.size(), m_ovf, m_unf, m_pop, m_npop, m_ntrap});
    if (busy > 0) begin
      repeat (busy) @(posedge clk);
      #1 alu_busy = 0;
    end
  endtask

  initial begin
    logic [7:0] jl[6];
    logic [7:0] cl[6];
    logic [7:0] nl[6];
    logic [7:0] code;
    int busy;
    int prev_pc;
    jl = '{8'hC4, 8'hD4, 8'hC5, 8'hD5, 8'hC6, 8'hD6};
    cl = '{8'hC7, 8'hD7, 8'hC8, 8'hD8, 8'hC9, 8'hD9};
    nl = '{8'hC0, 8'hCB, 8'hCF, 8'hD0, 8'hD1, 8'hDF};
    bus.op_valid = 0; bus.op_code = 0; bus.op_val = 0; bus.op_a = 0; bus.cond = 0;

    do_reset(3);
    wait_ready();
    repeat (5) @(negedge clk);
    chk("idle_op_ready", 64'(bus.op_ready), 64'd1);
    chk("idle_pc", 64'(pc), 64'd0);

    issue(8'hC4, 32'd3, 32'd0, 1'b0, 0);
    issue(8'hC7, 32'd9, 32'd0, 1'b0, 0);
    wait_ready();
    chk("cud_pc", 64'(pc), 64'd9);
    chk("cud_sp_cnt", 64'(sp_cnt), 64'd1);
    issue(8'hCA, 32'd0, 32'd0, 1'b0, 0);
    wait_ready();
    chk("rtu_pc", 64'(pc), 64'd4);
    chk("rtu_pop_data", 64'(pop_data), 64'd4);

    for (int i = 0; i < 17; i++) issue(8'hC1, 32'(i), 32'hDEAD_0000, 1'b0, 0);
    wait_ready();
    chk("ovf_flag", 64'(stk_ovf), 64'd1);
    chk("ovf_sp_cnt", 64'(sp_cnt), 64'd16);
    for (int i = 0; i < 16; i++) begin
      issue(8'hC2, 32'd0, 32'd0, 1'b0, 0);
      wait_ready();
      chk("pop_order", 64'(pop_data), 64'(15 - i));
    end
    issue(8'hC2, 32'd0, 32'd0, 1'b0, 0);
    wait_ready();
    chk("unf_flag", 64'(stk_unf), 64'd1);
    chk("unf_pop_data", 64'(pop_data), 64'd0);

    issue(8'hC4, 32'd14, 32'd0, 1'b0, 0);
    issue(8'hD5, 32'd5, 32'd0, 1'b0, 0);
    wait_ready();
    chk("jcp_cond0", 64'(pc), 64'd15);
    issue(8'hC4, 32'd14, 32'd0, 1'b0, 0);
    issue(8'hD5, 32'd5, 32'd0, 1'b1, 0);
    wait_ready();
    chk("jcp_cond1_wrap", 64'(pc), 64'd3);

    prev_pc = int'(pc);
    issue(8'h1A, 32'd0, 32'd0, 1'b0, 4);
    wait_ready();
    chk("alu_pc", 64'(pc), 64'((prev_pc + 1) % NPC));

    issue(8'hE1, 32'd1, 32'hCAFE_F00D, 1'b0, 0);
    issue(8'hC2, 32'd0, 32'd0, 1'b0, 0);
    wait_ready();
    chk("psh_op_a", 64'(pop_data), 64'hCAFE_F00D);
    issue(8'hC3, 32'h0000_0103, 32'd0, 1'b0, 0);
    wait_ready();
    chk("mvs_clamp", 64'(sp_cnt), 64'd16);
    issue(8'hC3, 32'd0, 32'd0, 1'b0, 0);

    wait_ready();
    bus.op_valid = 1; bus.op_code = 8'h1A; alu_busy = 1;
    @(posedge clk);
    #1 bus.op_valid = 0;
    @(negedge clk);
    @(negedge clk);
    do_reset(1);

`ifdef PCSTK_TRAP_EN
    issue(8'hC4, 32'd7, 32'd0, 1'b0, 0);
    issue(8'hC2, 32'd0, 32'd0, 1'b0, 0);
    wait_ready();
    chk("trap_pc_zero", 64'(pc), 64'd0);
`else
    issue(8'hC4, 32'd7, 32'd0, 1'b0, 0);
    issue(8'hC2, 32'd0, 32'd0, 1'b0, 0);
    wait_ready();
    chk("fault_pc_inc", 64'(pc), 64'd8);
`endif
    chk("fault_unf", 64'(stk_unf), 64'd1);

    for (int k = 0; k < 300; k++) begin
      if (k % 100 == 99) begin
        wait_ready();
        do_reset(2);
      end
      busy = 0;
      case ($urandom_range(0, 11))
        0: begin code = 8'($urandom_range(0, 191)); busy = $urandom_range(0, 3); end
        1, 2: code = ($urandom_range(0, 1) == 1) ? 8'hE1 : 8'hC1;
        3, 4: code = 8'hC2;
        5: code = 8'hC3;
        6: code = jl[$urandom_range(0, 5)];
        7: code = cl[$urandom_range(0, 5)];
        8: code = ($urandom_range(0, 1) == 1) ? 8'hDA : 8'hCA;
        default: code = nl[$urandom_range(0, 5)];
      endcase
      if (code == 8'hC3) issue(code, 32'($urandom_range(0, m_stk.size())), $urandom, 1'($urandom), 0);
      else issue(code, $urandom, $urandom, 1'($urandom), busy);
    end

    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) chk("drain_pending", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_stack_ctrl.md
Name: pc_stack_ctrl

Overview:
Program-sequencing controller for the processor datapath. Owns the program counter and a hardware call/return stack. Walks through fetch, decode and execute phases, with a valid/ready handshake toward the decoder. Applies control-flow and stack opcodes itself, and holds the PC while the ALU finishes multi-cycle shift/rotate operations (alu_busy).

Parameters:
DATA_W, 32, width of immediate/register/stack data
PC_W, 4, program counter width; PC wraps modulo 2^PC_W
SPTR_W, 4, stack depth = 2^SPTR_W entries (default 16)

Ports:
clkout  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
op_valid  in  1  decoder presents an opcode
op_ready  out  1  controller accepts opcode this cycle
op_code  in  8  opcode
op_val  in  DATA_W  immediate operand
op_a  in  DATA_W  register A value (for JUA/CUA, PSH source when op_code[5]=1)
cond  in  1  condition flag for conditional forms
alu_busy  in  1  ALU multi-cycle operation in progress
pc  out  PC_W  current program counter
fetch_en  out  1  one-cycle instruction fetch strobe at pc
sp_cnt  out  SPTR_W+1  number of stack entries, 0..2^SPTR_W
pop_data  out  DATA_W  last popped word
pop_valid  out  1  one-cycle strobe with pop_data
stk_ovf  out  1  sticky overflow flag
stk_unf  out  1  sticky underflow flag
trap  out  1  one-cycle stack-fault trap strobe (only with PCSTK_TRAP_EN)

Behaviour:
- Reset (rst=1 at posedge) values:
  - pc=0, sp_cnt=0, pop_data=0; pop_valid, stk_ovf, stk_unf, trap, fetch_en, op_ready all 0.
  - FSM goes to S_FETCH.
  - Reset has priority over everything, including mid-operation: a pending op is discarded and stack contents are don't-care.
- FSM states:
  - S_FETCH: fetch_en=1 for one cycle -> S_DECODE.
  - S_DECODE: op_ready=1; stays until op_valid. When op_valid&op_ready, latch op_code/op_val/op_a/cond.
    - Control op -> S_EXEC.
    - Any other op (ALU class, op_code[7:6]!=2'b11) -> S_WAIT.
  - S_EXEC: one cycle; performs stack/PC update -> S_FETCH.
  - S_WAIT: holds until alu_busy=0 (checked from the cycle after acceptance), then pc=pc+1 -> S_FETCH.
- Control opcodes (op_code[7:6]=2'b11; op_code[4]=1 marks the conditional form, executed only if the latched cond=1, otherwise pc=pc+1):
  - 0xC0 NOP: pc+1.
  - 0xC1 PSH: push op_val (op_a if op_code[5]=1); pc+1.
  - 0xC2 POP: pop to pop_data, pop_valid=1; pc+1.
  - 0xC3 MVS: sp_cnt=min(op_val, 2^SPTR_W); pc+1.
  - 0xC4/D4 JUD/JCD: pc=op_val[PC_W-1:0].
  - 0xC5/D5 JUP/JCP: pc=pc+op_val[PC_W-1:0] (wrap).
  - 0xC6/D6 JUA/JCA: pc=op_a[PC_W-1:0].
  - 0xC7/D7 CUD/CCD, 0xC8/D8 CUP/CCP, 0xC9/D9 CUA/CCA: push zero-extended pc+1, then jump as the matching J-form.
  - 0xCA/DA RTU/RTC: pop; pc=popped[PC_W-1:0]; pop_valid=1.
  - Undefined 0xC?/0xD? codes act as NOP.
- Op-to-fetch latency: control op = 2 cycles after acceptance; ALU op = 2 cycles + busy time.
- Stack is full-descending internally, but only sp_cnt is visible.
- Stack boundaries:
  - Push when sp_cnt=2^SPTR_W: no write; stk_ovf set (sticky until rst); call is not taken, pc=pc+1.
  - Pop/return when sp_cnt=0: pop_data unchanged, no pop_valid; stk_unf set; pc=pc+1.
  - Push then pop of the same entry returns the exact DATA_W word; return addresses keep their upper bits at 0.

Optional Feature:
PCSTK_TRAP_EN
- Defined: any overflow/underflow event also pulses trap for one cycle (the S_EXEC->S_FETCH edge) and forces pc=0 instead of pc+1.
- Undefined: trap is tied 0 and faults only set the sticky flags, with pc+1.

Test Plan:
- Reset then idle -> pc=0, sp_cnt=0, fetch_en pulses once, op_ready=1 held in S_DECODE.
- pc=3, CUD op_val=9 -> pc=9, sp_cnt=1; then RTU -> pc=4, pop_data=4, pop_valid one cycle, sp_cnt=0.
- 16x PSH values 0..15, then a 17th PSH -> stk_ovf=1, sp_cnt=16; 16 POPs return 15..0; extra POP -> stk_unf=1, pop_data stays 0.
- JCP op_val=5 at pc=14 with cond=0 -> pc=15; with cond=1 -> pc=3 (wrap).
- ALU op 0x1A accepted with alu_busy high 4 cycles -> pc increments only after alu_busy falls, then fetch_en.
- rst asserted during S_WAIT -> next cycle pc=0, sp_cnt=0, flags clear; with PCSTK_TRAP_EN, a POP on an empty stack -> trap=1 one cycle, pc=0.
